relu_maxpool2d: RTL
===================

Name: relu_maxpool2d

Overview:
- Consumes the multi-channel Q-format feature maps produced by the convolution stage.
- Applies a fused ReLU and non-overlapping POOLxPOOL max-pool per channel.
- Writes a down-sampled feature map for the next stage (flatten/dense).
- Start/done controlled; processes one input sample per clock through a time-multiplexed comparator.

Parameters:
- DATA_WIDTH, 16, signed word width of input and output samples (same Q format in and out; no scaling).
- CHANNELS, 8, number of feature maps (equals the upstream OUT_CHANNELS).
- IMG_SIZE, 28, input square map size (HxW).
- POOL, 2, pooling window size and stride; OUT_SIZE = IMG_SIZE/POOL (integer floor).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, pulse; starts a full pass when idle.
- in_feature, input, signed [DATA_WIDTH-1:0] [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1], input maps; held stable from start until done.
- out_feature, output, signed [DATA_WIDTH-1:0] [0:CHANNELS-1][0:OUT_SIZE-1][0:OUT_SIZE-1], registered pooled maps.
- busy, output, 1, high while a pass is in progress (any state other than IDLE).
- done, output, 1, one-cycle pulse at completion.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: state=IDLE; done=0; busy=0; every out_feature element=0; all counters=0; max register=0.
- States: IDLE, SCAN, WRITE, FINISH.
- IDLE:
  - start=1 clears ch/orow/ocol/pr/pc, loads max=0, and moves to SCAN.
  - start=0 stays in IDLE.
- SCAN: one sample per cycle at row orow*POOL+pr, col ocol*POOL+pc of channel ch.
  - max <= (sample > max) ? sample : max, as a signed compare.
  - pc advances first, then pr.
  - After the tap with pr=pc=POOL-1, go to WRITE.
- WRITE:
  - out_feature[ch][orow][ocol] <= max. Because max is seeded with 0, this equals max(0, window max), i.e. ReLU fused.
  - Reload max=0 and clear pr/pc.
  - Advance ocol, then orow, then ch, with wrap to 0.
  - After the last element (ch=CHANNELS-1, orow=ocol=OUT_SIZE-1), go to FINISH; otherwise return to SCAN.
- FINISH: done <= 1 for exactly one cycle; state <= IDLE.
- Latency:
  - Take the edge that samples start as edge 0.
  - done is high in the cycle following edge CHANNELS*OUT_SIZE^2*(POOL*POOL+1)+1.
  - Default parameters: 8*196*5+1 = 7841.
- busy: high from the cycle after start is sampled through the FINISH cycle; low in the cycle where done is high.
- start while busy: ignored; no restart, no effect on counters.
- start in the same cycle done is high: accepted, since state is IDLE.
- Non-divisible IMG_SIZE: trailing IMG_SIZE mod POOL rows/cols are never read.
- Arithmetic:
  - Pure signed compare, no widening, no rounding, no saturation needed.
  - The most-negative input (-2^(DATA_WIDTH-1)) yields 0.
- Output retention: out_feature elements keep their last written value between passes. A new pass overwrites each element in raster order (ch, orow, ocol); unwritten elements hold old data mid-pass.
- Reset mid-operation: immediate return to IDLE next edge; outputs cleared to 0; no done pulse.

Test Plan:
- Reset: assert reset 2 cycles -> done=0, busy=0, all out_feature=0.
- Basic pool (CHANNELS=1, IMG_SIZE=4, POOL=2), input rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, pulse start:
  - out = {6,8},{14,16}.
  - done high exactly after edge 21; busy low in that cycle.
- ReLU:
  - Window {-5,-1,-7,-32768} -> 0.
  - Window {-3,2,-1,-4} -> 2.
  - Window {32767,-32768,0,0} -> 32767.
- Multi-channel (CHANNELS=2, IMG_SIZE=4): ch0 all 100, ch1 all -100 -> ch0 outputs 100, ch1 outputs 0; done after edge 41.
- Odd size (IMG_SIZE=5, POOL=2): row 4 and col 4 filled with 1000, rest 1 -> all four outputs = 1; row/col 4 never influences results.
- Control:
  - Re-pulse start at edge 5 of a run -> ignored; completion timing unchanged.
  - Assert reset at edge 10 -> no done pulse; outputs 0; a fresh start then completes normally.

Source files
------------

// File: rtl/relu_maxpool2d.sv
// Fused ReLU + non-overlapping POOLxPOOL max-pool over CHANNELS square feature maps.
// One input sample is compared per clock; each finished window is written to a registered output map.
module relu_maxpool2d #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int POOL       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_feature  [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] out_feature [0:CHANNELS-1][0:IMG_SIZE/POOL-1][0:IMG_SIZE/POOL-1],
  output logic                         busy,
  output logic                         done
);

  localparam int OUT_SIZE = IMG_SIZE / POOL;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OS_W     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int P_W      = (POOL > 1)     ? $clog2(POOL)     : 1;
  localparam int IDX_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, FINISH} state_t;

  state_t                        state, state_nxt;
  logic [CH_W-1:0]               ch;
  logic [OS_W-1:0]               orow, ocol;
  logic [P_W-1:0]                pr, pc;
  logic signed [DATA_WIDTH-1:0]  max_q;
  logic signed [DATA_WIDTH-1:0]  sample;
  logic [IDX_W-1:0]              row_idx, col_idx;
  logic                          last_tap, last_elem;

  // Trailing IMG_SIZE mod POOL rows/cols are never addressed by these indices.
  assign row_idx = IDX_W'(orow) * IDX_W'(POOL) + IDX_W'(pr);
  assign col_idx = IDX_W'(ocol) * IDX_W'(POOL) + IDX_W'(pc);
  assign sample  = in_feature[ch][row_idx][col_idx];

  assign last_tap  = (pr == P_W'(POOL - 1)) && (pc == P_W'(POOL - 1));
  assign last_elem = (ch == CH_W'(CHANNELS - 1)) &&
                     (orow == OS_W'(OUT_SIZE - 1)) && (ocol == OS_W'(OUT_SIZE - 1));

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_tap) state_nxt = WRITE;
      WRITE:   state_nxt = last_elem ? FINISH : SCAN;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch    <= '0;
      orow  <= '0;
      ocol  <= '0;
      pr    <= '0;
      pc    <= '0;
      max_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FINISH);
      unique case (state)
        IDLE: begin
          if (start) begin
            ch    <= '0;
            orow  <= '0;
            ocol  <= '0;
            pr    <= '0;
            pc    <= '0;
            max_q <= '0;
          end
        end
        SCAN: begin
          if (sample > max_q) max_q <= sample;
          if (pc != P_W'(POOL - 1)) begin
            pc <= pc + 1'b1;
          end else begin
            pc <= '0;
            if (pr != P_W'(POOL - 1)) pr <= pr + 1'b1;
          end
        end
        WRITE: begin
          // Seeding with 0 makes the stored window maximum already ReLU'd.
          max_q <= '0;
          pr    <= '0;
          pc    <= '0;
          if (ocol != OS_W'(OUT_SIZE - 1)) begin
            ocol <= ocol + 1'b1;
          end else begin
            ocol <= '0;
            if (orow != OS_W'(OUT_SIZE - 1)) begin
              orow <= orow + 1'b1;
            end else begin
              orow <= '0;
              ch   <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the output map is a register array that must read 0 after reset, so every element is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int r = 0; r < OUT_SIZE; r++)
          for (int k = 0; k < OUT_SIZE; k++)
            out_feature[c][r][k] <= '0;
    end else if (state == WRITE) begin
      out_feature[ch][orow][ocol] <= max_q;
    end
  end

endmodule
